countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Programmable down-counting interval timer, the counterpart of the free-running up-counting seconds timer.
- A value is loaded, and the timer decrements once per prescaled tick until it reaches zero. It then flags expiry.
- Used by control FSMs and display logic for timeouts and countdown displays.
- Prescaler and state machine are internal; the whole block runs on a single clock.

Parameters:
- WIDTH, 4, width of the loaded value and of `remaining`.
- TICK_CYCLES, 1000000, clock cycles per decrement. Must be >= 2. Prescaler width is $clog2(TICK_CYCLES).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  load `load_value`; single-cycle strobe, sampled each edge.
- load_value  input  WIDTH  count value captured on `load`.
- start  input  1  start or resume counting; sampled each edge.
- pause  input  1  freeze counting; sampled each edge.
- remaining  output  WIDTH  current count, registered.
- running  output  1  high while in state RUN.
- expired  output  1  one-cycle pulse on reaching zero.
- done  output  1  high while in state DONE.

Behaviour:
- **Reset.**
  - Applies immediately when `reset` goes low, with no clock edge needed.
  - Clears `remaining`, prescaler, the reload register, `expired`, `done` and `running` to 0. State becomes IDLE.
- **States.**
  - IDLE: `running=0`, `done=0`.
  - RUN: `running=1`.
  - PAUSED: `running=0`.
  - DONE: `done=1`.
- **Priority.** Per edge: `load` > `pause` > `start`.
- **`load` (any state).**
  - `remaining <= load_value`; reload register `<= load_value`; prescaler `<= 0`; state `<= IDLE`; `expired <= 0`.
- **IDLE + `start`.**
  - If `remaining == 0`: go to DONE and pulse `expired`.
  - Otherwise go to RUN with prescaler `<= 0`.
- **RUN.**
  - Prescaler increments every cycle.
  - On the edge where prescaler == TICK_CYCLES-1: prescaler `<= 0` and `remaining <= remaining - 1`.
  - If that decrement produces 0, state `<= DONE` and `expired <= 1`.
  - First decrement occurs TICK_CYCLES edges after the edge that sampled `start`.
- **RUN + `pause`.**
  - That edge's prescaler update and any decrement still take effect, then state goes to PAUSED.
  - If that decrement reaches 0, DONE wins over PAUSED.
- **PAUSED.**
  - Prescaler and `remaining` hold.
  - `start` (with `pause` low) returns to RUN. Prescaler is not cleared, so the partial tick is preserved.
- **Ignored inputs.**
  - `start` in RUN.
  - `pause` in IDLE, PAUSED or DONE.
  - `start` in DONE; only `load` leaves DONE.
- **`expired`.** Registered. High for exactly one cycle, the cycle in which `remaining` first reads 0. Never high in two consecutive cycles.
- **Arithmetic.** `remaining` never wraps below 0. Decrement is unsigned WIDTH-bit.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- **Defined:** on a tick that would take `remaining` to 0, `remaining <= reload register` instead. `expired` pulses, state stays RUN and `done` is never set, giving periodic operation. A reload value of 0 still goes to DONE on `start`.
- **Undefined:** behaviour exactly as above, and the reload register is not synthesized.

Test Plan (WIDTH=4, TICK_CYCLES=4):
- **Basic countdown.** Reset, load 3, start at edge E0 → `remaining` 2/1/0 after E4/E8/E12. `expired`=1 only in the cycle after E12. `done`=1 and `running`=0 from E12.
- **Pause and resume.** Load 3, start E0, pause sampled at E6, hold 10 cycles, start sampled at E17 → decrements after E4, E19, E23. `remaining`=0 and `expired` pulse after E23.
- **Zero load.** Load 0, start → DONE after one edge, single `expired` pulse. A further `start` has no effect.
- **Asynchronous reset.** Assert `reset`=0 mid-count between clock edges → all outputs 0 before the next edge. After release, the block stays IDLE until load/start.
- **Load during RUN.** Load 5 while `remaining`=2 → `remaining`=5, IDLE, `done`=0. Simultaneous load+start → load wins, state IDLE.
- **Auto-reload (macro defined).** Load 2, start → `expired` pulses every 8 cycles. `remaining` sequence is 2,1,2,1…, and `done` stays 0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle of the countdown timer.
// master drives load/start/pause, slave (the timer) drives status.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] remaining;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output load,
    output load_value,
    output start,
    output pause,
    input  remaining,
    input  running,
    input  expired,
    input  done
  );

  modport slave (
    input  load,
    input  load_value,
    input  start,
    input  pause,
    output remaining,
    output running,
    output expired,
    output done
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: prescaled down-counter with IDLE/RUN/PAUSED/DONE FSM.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN for periodic auto-reload.
module countdown_timer #(
  parameter int WIDTH       = 4,
  parameter int TICK_CYCLES = 1000000
) (
  input logic              clock,
  input logic              reset,
  countdown_timer_if.slave tmr
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] TICK_MAX =
    PW'(TICK_CYCLES - 1);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic             exp_q;
  logic             exp_d;
  logic [WIDTH-1:0] wrap_val;
  logic             go;
  logic             tick;
  logic             last;

  assign go   = tmr.start & ~tmr.pause;
  assign tick = (state_q == RUN) &&
                (pre_q == TICK_MAX);
  assign last = (rem_q == WIDTH'(1));

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] rel_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rel_q <= '0;
    end else if (tmr.load) begin
      rel_q <= tmr.load_value;
    end
  end

  assign wrap_val = rel_q;
`else
  assign wrap_val = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a final tick outranks pause: DONE wins over PAUSED
  always_comb begin
    state_d = state_q;
    if (tmr.load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_d = (rem_q == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (tick && last && !AUTO_RELOAD) begin
            state_d = DONE;
          end else if (tmr.pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (go) begin
            state_d = RUN;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tmr.running = 1'b0;
    tmr.done    = 1'b0;
    unique case (state_q)
      RUN:     tmr.running = 1'b1;
      DONE:    tmr.done    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pre_d = pre_q;
    rem_d = rem_q;
    exp_d = 1'b0;
    if (tmr.load) begin
      rem_d = tmr.load_value;
      pre_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            pre_d = '0;
            exp_d = (rem_q == '0);
          end
        end
        RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (last) begin
              exp_d = 1'b1;
              rem_d = wrap_val;
            end else if (rem_q != '0) begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      rem_q <= '0;
      exp_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      rem_q <= rem_d;
      exp_q <= exp_d;
    end
  end

  assign tmr.remaining = rem_q;
  assign tmr.expired   = exp_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed plan plus random stimulus,
// checked against a cycle-level behavioural model.
module tb_countdown_timer;
  localparam int W = 4;
  localparam int T = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(
    .WIDTH      (W),
    .TICK_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tmr  (bus)
  );

  always #5 clock = ~clock;

  int n_run  = 0;
  int n_fail = 0;

  int m_mode;
  int m_rem;
  int m_ph;
  int m_rel;
  bit m_exp;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_rem  = 0;
    m_ph   = 0;
    m_rel  = 0;
    m_exp  = 1'b0;
  endtask

  task automatic model_step(input bit ld, input int lv,
                            input bit st, input bit pa);
    bit e;
    e = 1'b0;
    if (ld) begin
      m_rem  = lv;
      m_rel  = lv;
      m_ph   = 0;
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (st && !pa) begin
        if (m_rem == 0) begin
          m_mode = M_DONE;
          e = 1'b1;
        end else begin
          m_mode = M_RUN;
          m_ph   = 0;
        end
      end
    end else if (m_mode == M_RUN) begin
      m_ph++;
      if (m_ph == T) begin
        m_ph = 0;
        if (m_rem == 1) begin
          e = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          m_rem = m_rel;
`else
          m_rem  = 0;
          m_mode = M_DONE;
`endif
        end else begin
          m_rem--;
        end
      end
      if (m_mode == M_RUN && pa) m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE) begin
      if (st && !pa) m_mode = M_RUN;
    end
    m_exp = e;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rem"}, 32'(bus.remaining), 32'(m_rem));
    check({tag, ".run"}, 32'(bus.running),
          32'(m_mode == M_RUN));
    check({tag, ".done"}, 32'(bus.done),
          32'(m_mode == M_DONE));
    check({tag, ".exp"}, 32'(bus.expired), 32'(m_exp));
  endtask

  task automatic step(input string tag, input bit ld,
                      input int lv, input bit st,
                      input bit pa);
    bus.load       = ld;
    bus.load_value = W'(lv);
    bus.start      = st;
    bus.pause      = pa;
    @(posedge clock);
    model_step(ld, lv, st, pa);
    #1;
    check_all(tag);
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0);
  endtask

  initial begin
    int pulses;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b1;

    // basic countdown
    step("b_load", 1, 3, 0, 0);
    step("b_e0", 0, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step("basic", 0, 0, 0, 0);
`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      if (k == 4) check("b_e4", 32'(bus.remaining), 2);
      if (k == 8) check("b_e8", 32'(bus.remaining), 1);
      if (k == 12) begin
        check("b_e12_rem", 32'(bus.remaining), 0);
        check("b_e12_exp", 32'(bus.expired), 1);
        check("b_e12_done", 32'(bus.done), 1);
        check("b_e12_run", 32'(bus.running), 0);
      end
`endif
    end
    step("b_after", 0, 0, 0, 0);
    check("b_exp_low", 32'(bus.expired), 0);

    // pause and resume
    step("p_load", 1, 3, 0, 0);
    step("p_e0", 0, 0, 1, 0);
    idle_n("p_run", 5);
    step("p_e6", 0, 0, 0, 1);
    idle_n("p_hold", 10);
    step("p_e17", 0, 0, 1, 0);
    for (int k = 18; k <= 23; k++) begin
      step("p_resume", 0, 0, 0, 0);
      if (k == 19) check("p_e19", 32'(bus.remaining), 1);
    end
    check("p_e23_exp", 32'(bus.expired), 1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    check("p_e23_rem", 32'(bus.remaining), 3);
`else
    check("p_e23_rem", 32'(bus.remaining), 0);
`endif

    // zero load
    step("z_load", 1, 0, 0, 0);
    step("z_start", 0, 0, 1, 0);
    check("z_done", 32'(bus.done), 1);
    check("z_exp", 32'(bus.expired), 1);
    step("z_again", 0, 0, 1, 0);
    check("z_exp2", 32'(bus.expired), 0);
    idle_n("z_hold", 3);

    // asynchronous reset mid-count
    step("r_load", 1, 9, 0, 0);
    step("r_start", 0, 0, 1, 0);
    idle_n("r_run", 5);
    #2;
    reset = 1'b0;
    #1;
    check("r_rem", 32'(bus.remaining), 0);
    check("r_run0", 32'(bus.running), 0);
    check("r_done0", 32'(bus.done), 0);
    check("r_exp0", 32'(bus.expired), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle_n("r_post", 3);
    check("r_idle", 32'(bus.running), 0);

    // load during run, load beats start
    step("l_load", 1, 3, 0, 0);
    step("l_start", 0, 0, 1, 0);
    idle_n("l_run", 4);
    check("l_rem2", 32'(bus.remaining), 2);
    step("l_reload", 1, 5, 0, 0);
    check("l_rem5", 32'(bus.remaining), 5);
    check("l_idle", 32'(bus.running), 0);
    check("l_done", 32'(bus.done), 0);
    step("l_start2", 0, 0, 1, 0);
    idle_n("l_run2", 2);
    step("l_both", 1, 7, 1, 0);
    check("l_both_rem", 32'(bus.remaining), 7);
    check("l_both_idle", 32'(bus.running), 0);
    idle_n("l_stay", 2);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    step("a_load", 1, 2, 0, 0);
    step("a_start", 0, 0, 1, 0);
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      step("auto", 0, 0, 0, 0);
      if (bus.expired === 1'b1) pulses++;
    end
    check("a_pulses", 32'(pulses), 4);
`else
    pulses = 0;
`endif

    // random stimulus
    for (int i = 0; i < 400; i++) begin
      bit ld;
      bit st;
      bit pa;
      int lv;
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 3) == 0);
      pa = ($urandom_range(0, 7) == 0);
      lv = int'($urandom_range(0, (1 << W) - 1));
      step("rand", ld, lv, st, pa);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
